// File: rtl/turf_pkg.sv
// Shared constants and FSM state encoding for the territory ranking block.
package turf_pkg;

  localparam int unsigned COLOUR_W = 3;

  // Default player colours; 3'b000 is background and never owned
  localparam logic [COLOUR_W-1:0] COLOUR_P0 = 3'b001;
  localparam logic [COLOUR_W-1:0] COLOUR_P1 = 3'b010;
  localparam logic [COLOUR_W-1:0] COLOUR_P2 = 3'b100;
  localparam logic [COLOUR_W-1:0] COLOUR_P3 = 3'b110;

  // Default grid geometry (158 x 119 cells)
  localparam int unsigned GRID_X_W   = 8;
  localparam int unsigned GRID_Y_W   = 7;
  localparam int unsigned GRID_X_MAX = 157;
  localparam int unsigned GRID_Y_MAX = 118;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RANK  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/territory_rank.sv
// Combinational stable ranking network: highest count first, ties to lower index.
module territory_rank #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ID_W        = 2
) (
  input  logic [NUM_PLAYERS*CNT_W-1:0] i_counts,
  output logic [NUM_PLAYERS*ID_W-1:0]  o_ordered_ids
);

  logic [CNT_W-1:0] w_cnt  [NUM_PLAYERS];
  logic [ID_W-1:0]  w_rank [NUM_PLAYERS];

  // Unpack the flat count bus into per-player entries
  always_comb begin
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      w_cnt[i] = i_counts[i*CNT_W +: CNT_W];
    end
  end

  // Position of player i = number of players that beat it (strictly more, or equal with lower index)
  always_comb begin
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      w_rank[i] = '0;
      for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
        if ((w_cnt[j] > w_cnt[i]) || ((w_cnt[j] == w_cnt[i]) && (j < i))) begin
          w_rank[i] = w_rank[i] + ID_W'(1);
        end
      end
    end
  end

  // Scatter each player id into the slot its rank selects
  always_comb begin
    o_ordered_ids = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (w_rank[i] == ID_W'(k)) begin
          o_ordered_ids[k*ID_W +: ID_W] = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/territory_ranker.sv
// Scans a colour RAM, counts cells owned by each player and publishes a ranking.
module territory_ranker #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned X_W         = turf_pkg::GRID_X_W,
  parameter int unsigned Y_W         = turf_pkg::GRID_Y_W,
  parameter int unsigned X_MAX       = turf_pkg::GRID_X_MAX,
  parameter int unsigned Y_MAX       = turf_pkg::GRID_Y_MAX,
  parameter int unsigned COLOUR_W    = turf_pkg::COLOUR_W,
  localparam int unsigned CNT_W      = X_W + Y_W + 1,
  localparam int unsigned ID_W       = $clog2(NUM_PLAYERS)
) (
  input  logic                            clock25,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [NUM_PLAYERS*COLOUR_W-1:0] player_colours,
  output logic [X_W+Y_W-1:0]              rd_addr,
  input  logic [COLOUR_W-1:0]             rd_data,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_PLAYERS*CNT_W-1:0]    counts,
  output logic [NUM_PLAYERS*ID_W-1:0]     ordered_ids,
  output logic [NUM_PLAYERS*COLOUR_W-1:0] ordered_colours
);

  // Identity ordering used as the reset value of ordered_ids
  function automatic logic [NUM_PLAYERS*ID_W-1:0] f_identity();
    logic [NUM_PLAYERS*ID_W-1:0] v_ids;
    v_ids = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      v_ids[k*ID_W +: ID_W] = ID_W'(k);
    end
    return v_ids;
  endfunction

  localparam logic [NUM_PLAYERS*ID_W-1:0] IDS_RESET = f_identity();
  localparam logic [CNT_W-1:0]            CNT_SAT   = {CNT_W{1'b1}};

  turf_pkg::state_e r_state;
  turf_pkg::state_e w_state_nxt;

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_addr_vld;
  logic             r_data_vld;
  logic [CNT_W-1:0] r_cnt [NUM_PLAYERS];

  logic                          w_last;
  logic                          w_clr;
  logic                          w_issue;
  logic                          w_publish;
  logic                          w_any;
  logic [NUM_PLAYERS-1:0]        w_credit;
  logic [NUM_PLAYERS*CNT_W-1:0]  w_cnt_flat;
  logic [NUM_PLAYERS*ID_W-1:0]   w_rank_ids;

  assign w_last = (r_x == X_W'(X_MAX)) && (r_y == Y_W'(Y_MAX));

  // State register
  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      r_state <= turf_pkg::ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      turf_pkg::ST_IDLE:  if (start) w_state_nxt = turf_pkg::ST_SCAN;
      turf_pkg::ST_SCAN:  if (w_last) w_state_nxt = turf_pkg::ST_DRAIN;
      turf_pkg::ST_DRAIN: w_state_nxt = turf_pkg::ST_RANK;
      turf_pkg::ST_RANK:  w_state_nxt = turf_pkg::ST_DONE;
      turf_pkg::ST_DONE:  w_state_nxt = turf_pkg::ST_IDLE;
      default:            w_state_nxt = turf_pkg::ST_IDLE;
    endcase
  end

  // FSM control strobes for the datapath
  always_comb begin
    w_clr     = 1'b0;
    w_issue   = 1'b0;
    w_publish = 1'b0;
    case (r_state)
      turf_pkg::ST_IDLE: w_clr     = start;
      turf_pkg::ST_SCAN: w_issue   = 1'b1;
      turf_pkg::ST_DONE: w_publish = 1'b1;
      default: ;
    endcase
  end

  // Address generator: x inner loop, y outer loop, rd_addr frozen outside SCAN
  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      r_x        <= '0;
      r_y        <= '0;
      rd_addr    <= '0;
      r_addr_vld <= 1'b0;
      r_data_vld <= 1'b0;
    end else begin
      r_addr_vld <= w_issue;
      r_data_vld <= r_addr_vld;
      if (w_clr) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_issue) begin
        rd_addr <= {r_x, r_y};
        if (r_x == X_W'(X_MAX)) begin
          r_x <= '0;
          r_y <= r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
    end
  end

  // Credit a cell to the lowest-indexed player whose colour matches
  always_comb begin
    w_credit = '0;
    w_any    = 1'b0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (!w_any && (player_colours[i*COLOUR_W +: COLOUR_W] == rd_data)) begin
        w_credit[i] = 1'b1;
        w_any       = 1'b1;
      end
    end
  end

  // Saturating per-player cell counters
  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) r_cnt[i] <= '0;
    end else if (w_clr) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) r_cnt[i] <= '0;
    end else if (r_data_vld) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (w_credit[i] && (r_cnt[i] != CNT_SAT)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Flatten counters for the rank network and the published counts
  always_comb begin
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      w_cnt_flat[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  territory_rank #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .CNT_W       (CNT_W),
    .ID_W        (ID_W)
  ) u_rank (
    .i_counts      (w_cnt_flat),
    .o_ordered_ids (w_rank_ids)
  );

  // Status flags and result registers; results change only when leaving DONE
  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      counts      <= '0;
      ordered_ids <= IDS_RESET;
    end else begin
      busy <= (w_state_nxt != turf_pkg::ST_IDLE);
      done <= w_publish;
      if (w_publish) begin
        counts      <= w_cnt_flat;
        ordered_ids <= w_rank_ids;
      end
    end
  end

  // Colours follow the registered ids; player_colours is static, so this holds with them
  always_comb begin
    ordered_colours = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (ordered_ids[k*ID_W +: ID_W] == ID_W'(i)) begin
          ordered_colours[k*COLOUR_W +: COLOUR_W] = player_colours[i*COLOUR_W +: COLOUR_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_territory_ranker.sv
// Scoreboard bench for territory_ranker on a 4x2 grid (C = 8 cells).
module tb_territory_ranker;

  localparam int unsigned C = 8;

  typedef struct {
    logic [63:0] cnt;
    logic [7:0]  ids;
    logic [11:0] col;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start2;

  logic [11:0] pc1 = {3'b110, 3'b100, 3'b010, 3'b001};
  logic [5:0]  pc2 = {3'b010, 3'b010};

  logic [14:0] rd_addr1, rd_addr2;
  logic [2:0]  rd_data1, rd_data2;
  logic        busy1, busy2, done1, done2;
  logic [63:0] counts1;
  logic [31:0] counts2;
  logic [7:0]  ids1;
  logic [1:0]  ids2;
  logic [11:0] col1;
  logic [5:0]  col2;

  logic [2:0] mem1 [32768];
  logic [2:0] mem2 [32768];

  exp_t q1[$];
  exp_t q2[$];

  int unsigned cyc     = 0;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM models, one cycle read latency
  always @(posedge clk) rd_data1 <= mem1[rd_addr1];
  always @(posedge clk) rd_data2 <= mem2[rd_addr2];

  territory_ranker #(.NUM_PLAYERS(4), .X_MAX(3), .Y_MAX(1)) u_dut1 (
    .clock25(clk), .resetn(rst_n), .start(start1), .player_colours(pc1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1), .done(done1),
    .counts(counts1), .ordered_ids(ids1), .ordered_colours(col1)
  );

  territory_ranker #(.NUM_PLAYERS(2), .X_MAX(3), .Y_MAX(1)) u_dut2 (
    .clock25(clk), .resetn(rst_n), .start(start2), .player_colours(pc2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .done(done2),
    .counts(counts2), .ordered_ids(ids2), .ordered_colours(col2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Load 8 cells, cell k at x = k%4, y = k/4
  task automatic fill1(input logic [23:0] pat);
    for (int unsigned k = 0; k < C; k++) mem1[{8'(k % 4), 7'(k / 4)}] = pat[k*3 +: 3];
  endtask

  task automatic wait_idle1();
    for (int i = 0; i < 40 && busy1; i++) @(negedge clk);
    check("d1_busy_drop", 64'(busy1), 64'(0));
  endtask

  task automatic run1(input logic [23:0] pat, input logic [63:0] ec, input logic [7:0] ei,
                      input logic [11:0] ecol, input bit repulse);
    exp_t e;
    fill1(pat);
    @(negedge clk);
    e.cnt = ec; e.ids = ei; e.col = ecol; e.at = cyc + C + 4;
    q1.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("d1_busy_scan", 64'(busy1), 64'(1));
    if (repulse) begin
      repeat (2) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    wait_idle1();
    repeat (4) @(negedge clk);
  endtask

  // Scoreboard monitors: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL d1_unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = q1.pop_front();
        check("d1_counts", counts1, e.cnt);
        check("d1_ids", 64'(ids1), 64'(e.ids));
        check("d1_colours", 64'(col1), 64'(e.col));
        check("d1_done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        n_total++;
        $display("FAIL d2_unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = q2.pop_front();
        check("d2_counts", 64'(counts2), e.cnt);
        check("d2_ids", 64'(ids2), 64'(e.ids));
        check("d2_colours", 64'(col2), 64'(e.col));
        check("d2_done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    exp_t e2;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    fill1({8{3'b001}});
    for (int unsigned k = 0; k < C; k++) mem2[{8'(k % 4), 7'(k / 4)}] = 3'b010;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy1), 64'(0));
    check("rst_done", 64'(done1), 64'(0));
    check("rst_addr", 64'(rd_addr1), 64'(0));
    check("rst_counts", counts1, 64'(0));
    check("rst_ids", 64'(ids1), 64'(8'b11_10_01_00));
    check("rst_colours", 64'(col1), 64'(12'b110_100_010_001));
    check("rst_d2_ids", 64'(ids2), 64'(2'b10));
    check("rst_d2_colours", 64'(col2), 64'(6'b010_010));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All cells owned by player 0
    run1({8{3'b001}}, {16'd0, 16'd0, 16'd0, 16'd8}, 8'b11_10_01_00, 12'b110_100_010_001, 1'b0);

    // Mixed ownership 2/3/1/2 with a tie between players 0 and 3
    run1({3'b110, 3'b110, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001},
         {16'd2, 16'd1, 16'd3, 16'd2}, {2'd2, 2'd3, 2'd0, 2'd1}, {3'b100, 3'b110, 3'b001, 3'b010}, 1'b0);

    // Background only
    run1({8{3'b000}}, 64'(0), 8'b11_10_01_00, 12'b110_100_010_001, 1'b0);

    // Two-way ties plus unmatched colour 111
    run1({3'b010, 3'b001, 3'b000, 3'b111, 3'b100, 3'b100, 3'b110, 3'b110},
         {16'd2, 16'd2, 16'd1, 16'd1}, {2'd1, 2'd0, 2'd3, 2'd2}, {3'b010, 3'b001, 3'b110, 3'b100}, 1'b0);

    // Second start during SCAN must be ignored
    run1({8{3'b010}}, {16'd0, 16'd0, 16'd8, 16'd0}, {2'd3, 2'd2, 2'd0, 2'd1}, {3'b110, 3'b100, 3'b001, 3'b010}, 1'b1);

    // Reset in the fourth SCAN cycle aborts with no done
    fill1({8{3'b001}});
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy1), 64'(0));
    check("abort_done", 64'(done1), 64'(0));
    check("abort_counts", counts1, 64'(0));
    check("abort_ids", 64'(ids1), 64'(8'b11_10_01_00));
    check("abort_addr", 64'(rd_addr1), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run1({3'b110, 3'b110, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001},
         {16'd2, 16'd1, 16'd3, 16'd2}, {2'd2, 2'd3, 2'd0, 2'd1}, {3'b100, 3'b110, 3'b001, 3'b010}, 1'b0);

    // Two players with identical colours: lowest index takes every cell
    @(negedge clk);
    e2.cnt = {32'd0, 16'd0, 16'd8}; e2.ids = 8'b10; e2.col = 12'b010_010; e2.at = cyc + C + 4;
    q2.push_back(e2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("d2_busy_scan", 64'(busy2), 64'(1));
    for (int i = 0; i < 40 && busy2; i++) @(negedge clk);
    check("d2_busy_drop", 64'(busy2), 64'(0));
    repeat (4) @(negedge clk);

    check("d1_pending", 64'(q1.size()), 64'(0));
    check("d2_pending", 64'(q2.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
